// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared state encodings and operand-origin constants for the operand fetch sequencer.
`ifndef OPERAND_FETCH_SEQUENCER_PKG_SV
`define OPERAND_FETCH_SEQUENCER_PKG_SV

package operand_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_A = 2'd1,
    ST_FETCH_B = 2'd2,
    ST_VALID   = 2'd3
  } state_e;

  localparam logic ORIGIN_MAIN = 1'b0;
  localparam logic ORIGIN_REGS = 1'b1;

endpackage

`endif

// File: rtl/operand_fetch_sequencer.sv
// Fetches two operands through a shared input selector, one per cycle, then holds
// them valid until the consumer acknowledges.
module operand_fetch_sequencer
  import operand_fetch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned MAIN_INPUTS = 16,
  parameter int unsigned REGS_INPUTS = 64,
  localparam int unsigned MW = (MAIN_INPUTS > 1) ? $clog2(MAIN_INPUTS) : 1,
  localparam int unsigned RW = (REGS_INPUTS > 1) ? $clog2(REGS_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wStart,
  input  logic                  wOriginA,
  input  logic                  wOriginB,
  input  logic [MW-1:0]         wIdxMainA,
  input  logic [MW-1:0]         wIdxMainB,
  input  logic [RW-1:0]         wIdxRegsA,
  input  logic [RW-1:0]         wIdxRegsB,
  input  logic                  wAck,
  input  logic [DATA_WIDTH-1:0] r,
  output logic                  wBusy,
  output logic                  wSelecOrigin,
  output logic [MW-1:0]         wSelecMain,
  output logic [RW-1:0]         wSelecRegs,
  output logic [DATA_WIDTH-1:0] opA,
  output logic [DATA_WIDTH-1:0] opB,
  output logic                  ready,
  output logic                  valid,
  output logic                  err
);

  localparam logic [MW:0] MAIN_LIM = (MW+1)'(MAIN_INPUTS);
  localparam logic [RW:0] REGS_LIM = (RW+1)'(REGS_INPUTS);

  state_e                r_state;
  logic                  r_a_org, r_b_org;
  logic [MW-1:0]         r_a_main, r_b_main;
  logic [RW-1:0]         r_a_regs, r_b_regs;
  logic [DATA_WIDTH-1:0] r_op_a, r_op_b;
  logic                  r_err;
  logic                  r_busy, r_sel_org, r_ready, r_valid;
  logic [MW-1:0]         r_sel_main;
  logic [RW-1:0]         r_sel_regs;

  state_e        w_state_nxt;
  logic          w_latch;
  logic          w_a_main_ok, w_a_regs_ok, w_b_main_ok, w_b_regs_ok;
  logic          w_a_bad, w_b_bad;
  logic [MW-1:0] w_a_main_fix, w_b_main_fix;
  logic [RW-1:0] w_a_regs_fix, w_b_regs_fix;
  logic          w_a_org_nxt, w_b_org_nxt;
  logic [MW-1:0] w_a_main_nxt, w_b_main_nxt;
  logic [RW-1:0] w_a_regs_nxt, w_b_regs_nxt;
  logic          w_busy_nxt, w_sel_org_nxt, w_ready_nxt, w_valid_nxt;
  logic [MW-1:0] w_sel_main_nxt;
  logic [RW-1:0] w_sel_regs_nxt;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wStart) begin
          w_state_nxt = ST_FETCH_A;
          w_latch     = 1'b1;
        end
      end
      ST_FETCH_A: w_state_nxt = ST_FETCH_B;
      ST_FETCH_B: w_state_nxt = ST_VALID;
      ST_VALID: begin
        if (wAck) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Range check: only the side chosen by each operand's origin is sanitised and flagged
  always_comb begin
    w_a_main_ok  = ({1'b0, wIdxMainA} < MAIN_LIM);
    w_b_main_ok  = ({1'b0, wIdxMainB} < MAIN_LIM);
    w_a_regs_ok  = ({1'b0, wIdxRegsA} < REGS_LIM);
    w_b_regs_ok  = ({1'b0, wIdxRegsB} < REGS_LIM);
    w_a_bad      = (wOriginA == ORIGIN_MAIN) ? !w_a_main_ok : !w_a_regs_ok;
    w_b_bad      = (wOriginB == ORIGIN_MAIN) ? !w_b_main_ok : !w_b_regs_ok;
    w_a_main_fix = (wOriginA == ORIGIN_MAIN && !w_a_main_ok) ? '0 : wIdxMainA;
    w_b_main_fix = (wOriginB == ORIGIN_MAIN && !w_b_main_ok) ? '0 : wIdxMainB;
    w_a_regs_fix = (wOriginA == ORIGIN_REGS && !w_a_regs_ok) ? '0 : wIdxRegsA;
    w_b_regs_fix = (wOriginB == ORIGIN_REGS && !w_b_regs_ok) ? '0 : wIdxRegsB;
  end

  // Next values of the latched request and of the selector-facing outputs
  always_comb begin
    w_a_org_nxt    = w_latch ? wOriginA     : r_a_org;
    w_b_org_nxt    = w_latch ? wOriginB     : r_b_org;
    w_a_main_nxt   = w_latch ? w_a_main_fix : r_a_main;
    w_b_main_nxt   = w_latch ? w_b_main_fix : r_b_main;
    w_a_regs_nxt   = w_latch ? w_a_regs_fix : r_a_regs;
    w_b_regs_nxt   = w_latch ? w_b_regs_fix : r_b_regs;
    w_busy_nxt     = 1'b1;
    w_sel_org_nxt  = ORIGIN_MAIN;
    w_sel_main_nxt = '0;
    w_sel_regs_nxt = '0;
    w_ready_nxt    = 1'b0;
    w_valid_nxt    = 1'b0;
    case (w_state_nxt)
      ST_IDLE: w_ready_nxt = 1'b1;
      ST_FETCH_A: begin
        w_busy_nxt     = 1'b0;
        w_sel_org_nxt  = w_a_org_nxt;
        w_sel_main_nxt = w_a_main_nxt;
        w_sel_regs_nxt = w_a_regs_nxt;
      end
      ST_FETCH_B: begin
        w_busy_nxt     = 1'b0;
        w_sel_org_nxt  = w_b_org_nxt;
        w_sel_main_nxt = w_b_main_nxt;
        w_sel_regs_nxt = w_b_regs_nxt;
      end
      ST_VALID: w_valid_nxt = 1'b1;
      default: w_ready_nxt = 1'b1;
    endcase
  end

  // State, request latch, operand capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a_org    <= ORIGIN_MAIN;
      r_b_org    <= ORIGIN_MAIN;
      r_a_main   <= '0;
      r_b_main   <= '0;
      r_a_regs   <= '0;
      r_b_regs   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b1;
      r_sel_org  <= ORIGIN_MAIN;
      r_sel_main <= '0;
      r_sel_regs <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_org    <= w_a_org_nxt;
      r_b_org    <= w_b_org_nxt;
      r_a_main   <= w_a_main_nxt;
      r_b_main   <= w_b_main_nxt;
      r_a_regs   <= w_a_regs_nxt;
      r_b_regs   <= w_b_regs_nxt;
      if (w_latch) r_err <= w_a_bad | w_b_bad;
      if (r_state == ST_FETCH_A) r_op_a <= r;
      if (r_state == ST_FETCH_B) r_op_b <= r;
      r_busy     <= w_busy_nxt;
      r_sel_org  <= w_sel_org_nxt;
      r_sel_main <= w_sel_main_nxt;
      r_sel_regs <= w_sel_regs_nxt;
      r_ready    <= w_ready_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign wBusy        = r_busy;
  assign wSelecOrigin = r_sel_org;
  assign wSelecMain   = r_sel_main;
  assign wSelecRegs   = r_sel_regs;
  assign opA          = r_op_a;
  assign opB          = r_op_b;
  assign ready        = r_ready;
  assign valid        = r_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Bench for operand_fetch_sequencer with a behavioural input selector:
// main word i = i, register word j = j+1 (mod 16).
module tb_operand_fetch_sequencer;

  localparam int unsigned DW = 4;
  localparam int unsigned MI = 12;
  localparam int unsigned RI = 48;
  localparam int unsigned MW = 4;
  localparam int unsigned RW = 6;

  logic          clk, rst_n, wStart, wOriginA, wOriginB, wAck;
  logic [MW-1:0] wIdxMainA, wIdxMainB, wSelecMain;
  logic [RW-1:0] wIdxRegsA, wIdxRegsB, wSelecRegs;
  logic [DW-1:0] r, opA, opB;
  logic          wBusy, wSelecOrigin, ready, valid, err;

  int checks = 0;
  int errors = 0;

  operand_fetch_sequencer #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI)) u_dut (
    .clk(clk), .rst_n(rst_n), .wStart(wStart),
    .wOriginA(wOriginA), .wOriginB(wOriginB),
    .wIdxMainA(wIdxMainA), .wIdxMainB(wIdxMainB),
    .wIdxRegsA(wIdxRegsA), .wIdxRegsB(wIdxRegsB),
    .wAck(wAck), .r(r), .wBusy(wBusy), .wSelecOrigin(wSelecOrigin),
    .wSelecMain(wSelecMain), .wSelecRegs(wSelecRegs),
    .opA(opA), .opB(opB), .ready(ready), .valid(valid), .err(err)
  );

  // Selector model: with wBusy=1 the fetcher presents origin 0 / index 0, so main word 0 passes
  assign r = wSelecOrigin ? DW'(wSelecRegs + 6'd1) : wSelecMain;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic oa; int ma; int ra;
    logic ob; int mb; int rb;
    int   ea; int eb; logic ee;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input vec_t v);
    wOriginA  = v.oa; wIdxMainA = MW'(v.ma); wIdxRegsA = RW'(v.ra);
    wOriginB  = v.ob; wIdxMainB = MW'(v.mb); wIdxRegsB = RW'(v.rb);
  endtask

  task automatic scramble_req();
    wOriginA = ~wOriginA; wOriginB = ~wOriginB;
    wIdxMainA = ~wIdxMainA; wIdxMainB = ~wIdxMainB;
    wIdxRegsA = ~wIdxRegsA; wIdxRegsB = ~wIdxRegsB;
  endtask

  // One full fetch; request fields are scrambled after acceptance to prove they were latched
  task automatic run_txn(input int id, input vec_t v);
    string s;
    s = $sformatf("v%0d", id);
    drive_req(v);
    wStart = 1'b1;
    chk({s, "_idle_ready"}, 32'(ready), 32'd1);
    step();
    wStart = 1'b0;
    wAck   = 1'b1;
    scramble_req();
    chk({s, "_fa_busy"}, 32'(wBusy), 32'd0);
    chk({s, "_fa_org"}, 32'(wSelecOrigin), 32'(v.oa));
    chk({s, "_fa_ready"}, 32'(ready), 32'd0);
    step();
    chk({s, "_fb_org"}, 32'(wSelecOrigin), 32'(v.ob));
    chk({s, "_fb_opA"}, 32'(opA), 32'(v.ea));
    chk({s, "_fb_valid"}, 32'(valid), 32'd0);
    step();
    wAck = 1'b0;
    chk({s, "_v_valid"}, 32'(valid), 32'd1);
    chk({s, "_v_opA"}, 32'(opA), 32'(v.ea));
    chk({s, "_v_opB"}, 32'(opB), 32'(v.eb));
    chk({s, "_v_err"}, 32'(err), 32'(v.ee));
    chk({s, "_v_busy"}, 32'(wBusy), 32'd1);
    chk({s, "_v_selmain"}, 32'(wSelecMain), 32'd0);
    step();
    chk({s, "_hold_valid"}, 32'(valid), 32'd1);
    wAck = 1'b1;
    step();
    wAck = 1'b0;
    chk({s, "_ack_ready"}, 32'(ready), 32'd1);
    chk({s, "_ack_valid"}, 32'(valid), 32'd0);
    chk({s, "_ack_opB"}, 32'(opB), 32'(v.eb));
    chk({s, "_ack_err"}, 32'(err), 32'(v.ee));
  endtask

  task automatic start_to_valid(input vec_t v);
    drive_req(v);
    wStart = 1'b1;
    step();
    wStart = 1'b0;
    step();
    step();
  endtask

  initial begin
    int nvalid;
    int nready;
    vec_t t;

    //            oa  ma  ra   ob  mb  rb   ea  eb  ee
    vecs[0] = '{1'b0,  3,  0, 1'b1,  0, 10,  3, 11, 1'b0};
    vecs[1] = '{1'b1,  0,  0, 1'b0, 11,  0,  1, 11, 1'b0};
    vecs[2] = '{1'b1,  0, 47, 1'b1,  0, 15,  0,  0, 1'b0};
    vecs[3] = '{1'b0, 14,  0, 1'b0,  5,  0,  0,  5, 1'b1};
    vecs[4] = '{1'b1,  0, 50, 1'b0,  2,  0,  1,  2, 1'b1};
    vecs[5] = '{1'b0,  7,  0, 1'b0, 15,  0,  7,  0, 1'b1};
    vecs[6] = '{1'b0,  9,  0, 1'b1,  0, 30,  9, 15, 1'b0};
    vecs[7] = '{1'b1, 14,  4, 1'b0,  1, 63,  5,  1, 1'b0};

    rst_n = 1'b0; wStart = 1'b0; wAck = 1'b0;
    wOriginA = 1'b0; wOriginB = 1'b0;
    wIdxMainA = '0; wIdxMainB = '0; wIdxRegsA = '0; wIdxRegsB = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(wBusy), 32'd1);
    chk("rst_org", 32'(wSelecOrigin), 32'd0);
    chk("rst_opA", 32'(opA), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Continuous start and ack: one fetch per four cycles
    t = vecs[0];
    drive_req(t);
    wStart = 1'b1; wAck = 1'b1;
    nvalid = 0; nready = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (valid) nvalid++;
      if (ready) nready++;
    end
    wStart = 1'b0; wAck = 1'b0;
    chk("b2b_valid_cycles", 32'(nvalid), 32'd4);
    chk("b2b_ready_cycles", 32'(nready), 32'd4);
    chk("b2b_opB", 32'(opB), 32'd11);

    // Ack withheld for ten cycles, with starts that must be ignored
    start_to_valid(vecs[6]);
    wStart = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wait%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("wait%0d_ops", i), 32'({opA, opB}), 32'({4'd9, 4'd15}));
      chk($sformatf("wait%0d_busy", i), 32'(wBusy), 32'd1);
      step();
    end
    // Ack and start together: only the ack acts
    wAck = 1'b1;
    step();
    wAck = 1'b0;
    chk("ackstart_ready", 32'(ready), 32'd1);
    chk("ackstart_busy", 32'(wBusy), 32'd1);
    t = vecs[1];
    drive_req(t);
    step();
    wStart = 1'b0;
    chk("ackstart_next_fa", 32'(wBusy), 32'd0);
    chk("ackstart_next_org", 32'(wSelecOrigin), 32'd1);
    step();
    step();
    chk("ackstart_next_ops", 32'({opA, opB}), 32'({4'd1, 4'd11}));
    wAck = 1'b1;
    step();
    wAck = 1'b0;

    // Reset asserted during FETCH_B aborts immediately
    drive_req(vecs[0]);
    wStart = 1'b1;
    step();
    wStart = 1'b0;
    step();
    chk("abort_pre_opA", 32'(opA), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_ops", 32'({opA, opB}), 32'd0);
    chk("abort_busy", 32'(wBusy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(vecs[7]);
    wStart = 1'b1;
    step();
    wStart = 1'b0;
    chk("post_rst_fa_busy", 32'(wBusy), 32'd0);
    chk("post_rst_fa_org", 32'(wSelecOrigin), 32'd1);
    step();
    step();
    chk("post_rst_ops", 32'({opA, opB}), 32'({4'd5, 4'd1}));
    chk("post_rst_valid", 32'(valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
